// File: rtl/io_irq_ctrl.sv
// IO-mapped interrupt controller: enable mask, edge/level mode,
// W1C pending latches and a registered lowest-index request vector.
module io_irq_ctrl #(
  parameter logic [15:0] CAddrBase = 16'h0000,
  parameter int          CIrqCnt   = 16
) (
  input  logic               AClkH,
  input  logic               AResetHN,
  input  logic               AClkHEn,
  input  logic [15:0]        AIoAddr,
  output logic [63:0]        AIoMiso,
  input  logic [63:0]        AIoMosi,
  input  logic [3:0]         AIoWrSize,
  input  logic [3:0]         AIoRdSize,
  output logic               AIoAddrAck,
  output logic               AIoAddrErr,
  input  logic [CIrqCnt-1:0] AIrqI,
  output logic [CIrqCnt-1:0] AIrqO,
  output logic               AIrqReq,
  output logic [4:0]         AIrqIdx
);

  logic [CIrqCnt-1:0] en_q;
  logic [CIrqCnt-1:0] mode_q;
  logic [CIrqCnt-1:0] pend_q;
  logic [CIrqCnt-1:0] prev_q;
  logic               req_q;
  logic [4:0]         idx_q;

  logic [CIrqCnt-1:0] en_nxt;
  logic [CIrqCnt-1:0] mode_nxt;
  logic [CIrqCnt-1:0] pend_nxt;
  logic [CIrqCnt-1:0] w1c;
  logic [CIrqCnt-1:0] rise;
  logic [CIrqCnt-1:0] pend;
  logic [CIrqCnt-1:0] wdata;
  logic [4:0]         idx_nxt;

  logic       in_range;
  logic [3:0] off;
  logic [3:0] size;
  logic       wr_req;
  logic       rd_req;
  logic       legal;
  logic       hit;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] reg_sel;
  logic [31:0] rd32;
  logic       unused;

  assign in_range = AIoAddr[15:4] == CAddrBase[15:4];
  assign off      = AIoAddr[3:0];
  assign wr_req   = |AIoWrSize;
  assign rd_req   = |AIoRdSize;
  assign size     = AIoWrSize | AIoRdSize;
  assign legal    = (off[1:0] == 2'b00) && (size == 4'b0100);
  assign hit      = in_range & (wr_req | rd_req);

  assign AIoAddrAck = hit & legal;
  assign AIoAddrErr = hit & ~legal;

  assign wr_en   = AIoAddrAck & wr_req;
  assign rd_en   = AIoAddrAck & rd_req;
  assign reg_sel = 4'b0001 << off[3:2];
  assign wdata   = AIoMosi[CIrqCnt-1:0];
  assign unused  = ^{AIoMosi[63:CIrqCnt], CAddrBase[3:0]};

  assign en_nxt   = (wr_en & reg_sel[0]) ? wdata : en_q;
  assign mode_nxt = (wr_en & reg_sel[1]) ? wdata : mode_q;
  assign w1c      = (wr_en & reg_sel[2]) ? wdata : '0;
  assign rise     = AIrqI & ~prev_q;

  // Latch only lines that are edge now and stay edge; a 0->1 mode
  // change starts clean, and level lines keep the latch at zero.
  assign pend_nxt = mode_q & mode_nxt & ((pend_q & ~w1c) | rise);

  assign pend  = (pend_q & mode_q) | (AIrqI & ~mode_q);
  assign AIrqO = pend & en_q;

  always_comb begin
    idx_nxt = '0;
    for (int i = CIrqCnt - 1; i >= 0; i--) begin
      if (AIrqO[i]) idx_nxt = 5'(i);
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      en_q   <= '0;
      mode_q <= '0;
      pend_q <= '0;
      prev_q <= '0;
      req_q  <= 1'b0;
      idx_q  <= '0;
    end else if (AClkHEn) begin
      en_q   <= en_nxt;
      mode_q <= mode_nxt;
      pend_q <= pend_nxt;
      prev_q <= AIrqI;
      req_q  <= |AIrqO;
      idx_q  <= idx_nxt;
    end
  end

  assign AIrqReq = req_q;
  assign AIrqIdx = idx_q;

  always_comb begin
    rd32 = '0;
    if (rd_en) begin
      unique case (1'b1)
        reg_sel[0]: rd32[CIrqCnt-1:0] = en_q;
        reg_sel[1]: rd32[CIrqCnt-1:0] = mode_q;
        reg_sel[2]: rd32[CIrqCnt-1:0] = pend;
        reg_sel[3]: rd32 = {req_q, 26'b0, idx_q};
        default: rd32 = '0;
      endcase
    end
  end

  assign AIoMiso = {32'b0, rd32};

endmodule

// File: tb/tb_io_irq_ctrl.sv
// Directed bench for io_irq_ctrl with an expected-value queue.
// Inputs change on the falling edge; outputs sampled 1 ns later.
module tb_io_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic [15:0] addr;
  logic [63:0] miso;
  logic [63:0] mosi;
  logic [3:0]  wr_size;
  logic [3:0]  rd_size;
  logic        ack;
  logic        err;
  logic [15:0] irq_i;
  logic [15:0] irq_o;
  logic        req;
  logic [4:0]  idx;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  io_irq_ctrl #(.CAddrBase(16'h0000), .CIrqCnt(16)) dut (
    .AClkH     (clk),
    .AResetHN  (rst_n),
    .AClkHEn   (clk_en),
    .AIoAddr   (addr),
    .AIoMiso   (miso),
    .AIoMosi   (mosi),
    .AIoWrSize (wr_size),
    .AIoRdSize (rd_size),
    .AIoAddrAck(ack),
    .AIoAddrErr(err),
    .AIrqI     (irq_i),
    .AIrqO     (irq_o),
    .AIrqReq   (req),
    .AIrqIdx   (idx)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL sb_empty: observed %0h with no expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failed++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    addr    = a;
    mosi    = {32'hDEAD_BEEF, d};
    wr_size = 4'b0100;
    @(negedge clk);
    wr_size = 4'b0000;
    mosi    = '0;
  endtask

  task automatic io_rd(input string tag, input logic [15:0] a,
                       input logic [31:0] exp_d);
    push({tag, "_data"}, {32'b0, exp_d});
    push({tag, "_ack"}, 64'd1);
    @(negedge clk);
    addr    = a;
    rd_size = 4'b0100;
    #1;
    check(miso);
    check({63'b0, ack});
    rd_size = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    clk_en  = 1'b1;
    addr    = '0;
    mosi    = '0;
    wr_size = '0;
    rd_size = '0;
    irq_i   = '0;

    repeat (2) @(negedge clk);
    #1;
    push("rst_req", 64'd0);
    check({63'b0, req});
    push("rst_irq_o", 64'd0);
    check({48'b0, irq_o});
    @(negedge clk);
    rst_n = 1'b1;

    io_rd("rst_en", 16'h0, 32'h0);
    io_rd("rst_mode", 16'h4, 32'h0);
    io_rd("rst_pend", 16'h8, 32'h0);
    io_rd("rst_vec", 16'hC, 32'h0);

    // Level mode: transparent pending, one-cycle request latency
    io_wr(16'h0, 32'h0005);
    @(negedge clk);
    push("lvl_irq_o", 64'h4);
    irq_i = 16'h0004;
    #1 check({48'b0, irq_o});
    push("lvl_req", 64'd1);
    push("lvl_idx", 64'd2);
    @(negedge clk);
    #1 check({63'b0, req});
    check({59'b0, idx});
    push("lvl_drop", 64'd0);
    irq_i = 16'h0000;
    #1 check({48'b0, irq_o});
    push("lvl_req_drop", 64'd0);
    @(negedge clk);
    #1 check({63'b0, req});

    // Edge mode: latch a one-cycle pulse, then W1C
    io_wr(16'h4, 32'hFFFF);
    io_wr(16'h0, 32'hFFFF);
    @(negedge clk);
    irq_i = 16'h0080;
    @(negedge clk);
    irq_i = 16'h0000;
    push("edge_held", 64'h80);
    #1 check({48'b0, irq_o});
    push("edge_req", 64'd1);
    push("edge_idx", 64'd7);
    @(negedge clk);
    #1 check({63'b0, req});
    check({59'b0, idx});
    io_rd("edge_pend", 16'h8, 32'h0080);
    io_wr(16'h8, 32'h0080);
    push("w1c_irq_o", 64'd0);
    push("w1c_req_lag", 64'd1);
    #1 check({48'b0, irq_o});
    check({63'b0, req});
    push("w1c_req", 64'd0);
    @(negedge clk);
    #1 check({63'b0, req});

    // Set and clear collide: set wins
    @(negedge clk);
    irq_i   = 16'h0008;
    addr    = 16'h8;
    mosi    = 64'h8;
    wr_size = 4'b0100;
    @(negedge clk);
    wr_size = '0;
    irq_i   = '0;
    io_rd("set_wins", 16'h8, 32'h0008);
    io_wr(16'h8, 32'h0008);
    io_rd("clr3", 16'h8, 32'h0);

    // Priority: lowest index first
    @(negedge clk);
    irq_i = 16'h0210;
    @(negedge clk);
    irq_i = 16'h0000;
    push("prio_req", 64'd1);
    push("prio_idx4", 64'd4);
    @(negedge clk);
    #1 check({63'b0, req});
    check({59'b0, idx});
    io_rd("vec4", 16'hC, 32'h8000_0004);
    io_wr(16'h8, 32'h0010);
    push("prio_idx9", 64'd9);
    @(negedge clk);
    #1 check({59'b0, idx});
    io_wr(16'h8, 32'h0200);

    // Illegal size and offset
    push("byte_err", 64'd1);
    push("byte_ack", 64'd0);
    @(negedge clk);
    addr    = 16'h0;
    mosi    = 64'h1234;
    wr_size = 4'b0001;
    #1 check({63'b0, err});
    check({63'b0, ack});
    @(negedge clk);
    wr_size = '0;
    push("misalign_err", 64'd1);
    addr    = 16'h2;
    rd_size = 4'b0100;
    #1 check({63'b0, err});
    push("misalign_miso", 64'd0);
    check(miso);
    rd_size = '0;
    io_rd("byte_noeff", 16'h0, 32'hFFFF);

    // Clock enable low: no write, edge held for next enabled cycle
    @(negedge clk);
    clk_en  = 1'b0;
    addr    = 16'h0;
    mosi    = 64'h1;
    wr_size = 4'b0100;
    irq_i   = 16'h0020;
    @(negedge clk);
    wr_size = '0;
    clk_en  = 1'b1;
    @(negedge clk);
    io_rd("cen_en", 16'h0, 32'hFFFF);
    io_rd("cen_edge", 16'h8, 32'h0020);
    irq_i = '0;
    io_wr(16'h8, 32'h0020);

    // Asynchronous reset with a pending line
    @(negedge clk);
    irq_i = 16'h0001;
    @(negedge clk);
    irq_i = 16'h0000;
    push("pre_rst_req", 64'd1);
    @(negedge clk);
    #1 check({63'b0, req});
    #1 rst_n = 1'b0;
    push("arst_irq_o", 64'd0);
    push("arst_req", 64'd0);
    #1 check({48'b0, irq_o});
    check({63'b0, req});
    @(negedge clk);
    rst_n = 1'b1;
    io_rd("arst_en", 16'h0, 32'h0);
    io_rd("arst_mode", 16'h4, 32'h0);
    io_rd("arst_pend", 16'h8, 32'h0);

    if (sb.size() != 0) begin
      failed++;
      $error("FAIL sb_left: observed %0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
